// File: rtl/vga_sprite_overlay.sv
// Multi-sprite overlay for the VGA pixel path: solid rectangles over the background, 2-cycle latency.
// Defining VGA_OVL_COLLIDE_EN adds the per-frame sprite-0 collision flag on oHIT.
module vga_sprite_overlay #(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned NUM_SPRITES = 4,
    parameter int unsigned SPR_W       = 32,
    parameter int unsigned SPR_H       = 32,
    parameter int unsigned MOVE_DIV    = 2000000,
    parameter int unsigned STEP        = 1,
    parameter logic [24*NUM_SPRITES-1:0] SPR_COLOR = {NUM_SPRITES{24'h0000FF}}
) (
    input  logic        iVGA_CLK,
    input  logic        iRST_n,
    input  logic        iBLANK_n,
    input  logic        iVS,
    input  logic [23:0] iBG_BGR,
    input  logic [7:0]  iKEY,
    input  logic [2:0]  iSEL,
    output logic [23:0] oBGR,
    output logic        oBLANK_n,
    output logic        oHIT
);

    localparam int unsigned TICK_W = $clog2(MOVE_DIV);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(MOVE_DIV - 1);

    localparam logic [10:0] X_MAX  = 11'(H_ACTIVE - SPR_W);
    localparam logic [9:0]  Y_MAX  = 10'(V_ACTIVE - SPR_H);
    localparam logic [10:0] STEP_X = 11'(STEP);
    localparam logic [9:0]  STEP_Y = 10'(STEP);
    localparam logic [10:0] W_X    = 11'(SPR_W);
    localparam logic [9:0]  H_Y    = 10'(SPR_H);
    localparam logic [9:0]  X_LAST = 10'(H_ACTIVE - 1);
    localparam logic [8:0]  Y_LAST = 9'(V_ACTIVE - 1);

    localparam logic [7:0] KEY_RIGHT = 8'h74;
    localparam logic [7:0] KEY_LEFT  = 8'h6B;
    localparam logic [7:0] KEY_UP    = 8'h75;
    localparam logic [7:0] KEY_DOWN  = 8'h72;

    function automatic logic [10:0] init_x(input int unsigned idx);
        int unsigned pos;
        pos = idx * 2 * SPR_W;
        if (pos > H_ACTIVE - SPR_W) begin
            pos = H_ACTIVE - SPR_W;
        end
        init_x = 11'(pos);
    endfunction

    function automatic logic [10:0] move_x(input logic [10:0] pos, input logic [7:0] key);
        logic [11:0] inc;
        inc    = {1'b0, pos} + {1'b0, STEP_X};
        move_x = pos;
        if (key == KEY_RIGHT) begin
            move_x = (inc > {1'b0, X_MAX}) ? X_MAX : inc[10:0];
        end else if (key == KEY_LEFT) begin
            move_x = (pos < STEP_X) ? 11'd0 : pos - STEP_X;
        end
    endfunction

    function automatic logic [9:0] move_y(input logic [9:0] pos, input logic [7:0] key);
        logic [10:0] inc;
        inc    = {1'b0, pos} + {1'b0, STEP_Y};
        move_y = pos;
        if (key == KEY_DOWN) begin
            move_y = (inc > {1'b0, Y_MAX}) ? Y_MAX : inc[9:0];
        end else if (key == KEY_UP) begin
            move_y = (pos < STEP_Y) ? 10'd0 : pos - STEP_Y;
        end
    endfunction

    logic [9:0]        x_q, x_d;
    logic [8:0]        y_q, y_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic              tick;
    logic              vs_q;
    logic              commit;

    logic [10:0] pend_x_q [NUM_SPRITES];
    logic [10:0] pend_x_d [NUM_SPRITES];
    logic [9:0]  pend_y_q [NUM_SPRITES];
    logic [9:0]  pend_y_d [NUM_SPRITES];
    logic [10:0] act_x_q  [NUM_SPRITES];
    logic [10:0] act_x_d  [NUM_SPRITES];
    logic [9:0]  act_y_q  [NUM_SPRITES];
    logic [9:0]  act_y_d  [NUM_SPRITES];

    logic [NUM_SPRITES-1:0] hit;
    logic [NUM_SPRITES-1:0] hit_s1_q;
    logic [23:0]            bg_s1_q;
    logic                   blank_s1_q;
    logic [23:0]            pix;

    // Raster position: held at the origin through vertical sync, advanced only on active pixels.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (!iVS) begin
            x_d = '0;
            y_d = '0;
        end else if (iBLANK_n) begin
            if (x_q == X_LAST) begin
                x_d = '0;
                if (y_q != Y_LAST) begin
                    y_d = y_q + 9'd1;
                end
            end else begin
                x_d = x_q + 10'd1;
            end
        end
    end

    always_comb begin
        tick   = (tick_q == TICK_LAST);
        tick_d = tick ? '0 : tick_q + TICK_W'(1);
        commit = vs_q & ~iVS;
    end

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            x_q    <= '0;
            y_q    <= '0;
            tick_q <= '0;
            vs_q   <= 1'b0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            tick_q <= tick_d;
            vs_q   <= iVS;
        end
    end

    // Commit samples the pending set before this cycle's tick, so a coincident move lands a frame later.
    always_comb begin
        for (int i = 0; i < NUM_SPRITES; i++) begin
            pend_x_d[i] = pend_x_q[i];
            pend_y_d[i] = pend_y_q[i];
            act_x_d[i]  = commit ? pend_x_q[i] : act_x_q[i];
            act_y_d[i]  = commit ? pend_y_q[i] : act_y_q[i];
            if (tick && (iSEL == 3'(i))) begin
                pend_x_d[i] = move_x(pend_x_q[i], iKEY);
                pend_y_d[i] = move_y(pend_y_q[i], iKEY);
            end
        end
    end

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                pend_x_q[i] <= init_x(i);
                pend_y_q[i] <= '0;
                act_x_q[i]  <= init_x(i);
                act_y_q[i]  <= '0;
            end
        end else begin
            pend_x_q <= pend_x_d;
            pend_y_q <= pend_y_d;
            act_x_q  <= act_x_d;
            act_y_q  <= act_y_d;
        end
    end

    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            hit[i] = ({1'b0, x_q} >= act_x_q[i]) && ({1'b0, x_q} < act_x_q[i] + W_X) &&
                     ({1'b0, y_q} >= act_y_q[i]) && ({1'b0, y_q} < act_y_q[i] + H_Y);
        end
    end

    // Walk from the highest index down so the lowest covering sprite has the final say.
    always_comb begin
        pix = bg_s1_q;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (hit_s1_q[i]) begin
                pix = SPR_COLOR[24*i +: 24];
            end
        end
    end

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            hit_s1_q   <= '0;
            bg_s1_q    <= '0;
            blank_s1_q <= 1'b0;
            oBGR       <= '0;
            oBLANK_n   <= 1'b0;
        end else begin
            hit_s1_q   <= hit;
            bg_s1_q    <= iBG_BGR;
            blank_s1_q <= iBLANK_n;
            oBGR       <= blank_s1_q ? pix : 24'h0;
            oBLANK_n   <= blank_s1_q;
        end
    end

`ifdef VGA_OVL_COLLIDE_EN
    logic sticky_q;
    logic hit_q;
    logic others;

    always_comb begin
        others = 1'b0;
        for (int i = 1; i < NUM_SPRITES; i++) begin
            others = others | hit_s1_q[i];
        end
    end

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            sticky_q <= 1'b0;
            hit_q    <= 1'b0;
        end else if (commit) begin
            hit_q    <= sticky_q;
            sticky_q <= 1'b0;
        end else if (blank_s1_q && hit_s1_q[0] && others) begin
            sticky_q <= 1'b1;
        end
    end

    assign oHIT = hit_q;
`else
    assign oHIT = 1'b0;
`endif

endmodule

// File: doc/vga_sprite_overlay.md
# vga_sprite_overlay

Parametrised multi-sprite overlay stage for the VGA pixel path. Sits between the palette lookup (background BGR) and the output latch. Tracks the raster position with incremental counters (no divide/modulo). Composites `NUM_SPRITES` solid-colour rectangles over the background, moving one keyboard-selected sprite from PS/2 make codes, with tear-free per-frame position commit and optional collision flag.

## Interface

Parameters:
- `H_ACTIVE`, 640: visible pixels per line.
- `V_ACTIVE`, 480: visible lines per frame.
- `NUM_SPRITES`, 4: sprite count, 1..8.
- `SPR_W`, 32: sprite width in pixels, shared by all sprites.
- `SPR_H`, 32: sprite height in lines, shared by all sprites.
- `MOVE_DIV`, 2000000: clock cycles per movement tick, ≥2.
- `STEP`, 1: pixels moved per tick.
- `SPR_COLOR`, {NUM_SPRITES{24'h0000FF}}: packed BGR colours; sprite i uses bits [24i+23:24i].

Ports:
- `iVGA_CLK`  in  1: pixel clock.
- `iRST_n`  in  1: reset, asynchronous, active-low.
- `iBLANK_n`  in  1: active-video qualifier from the sync generator.
- `iVS`  in  1: vertical sync, active-low.
- `iBG_BGR`  in  24: background pixel, aligned with `iBLANK_n`.
- `iKEY`  in  8: current PS/2 make code.
- `iSEL`  in  3: index of the sprite steered by `iKEY`.
- `oBGR`  out  24: composited pixel.
- `oBLANK_n`  out  1: `iBLANK_n` delayed to match `oBGR`.
- `oHIT`  out  1: sprite-0 collision flag for the previous frame.

## Operation

- Raster counters `x` (10b) and `y` (9b) are held at 0 while `iVS`=0.
  - On each cycle with `iBLANK_n`=1, `x` increments.
  - At `x`=H_ACTIVE-1, `x` wraps to 0 and `y` increments.
  - `y` saturates at V_ACTIVE-1.
- Tick counter runs 0..MOVE_DIV-1 and wraps. `tick` is asserted in the cycle the count equals MOVE_DIV-1.
- On `tick`, the pending position of sprite `iSEL` is updated by `iKEY`:
  - 8'h74: x+STEP.
  - 8'h6B: x−STEP.
  - 8'h75: y−STEP.
  - 8'h72: y+STEP.
  - Any other code: no move.
- Positions saturate to x∈[0, H_ACTIVE−SPR_W] and y∈[0, V_ACTIVE−SPR_H]. Moves never wrap.
- `iSEL` ≥ NUM_SPRITES: no sprite moves.
- Commit: on the first cycle of `iVS`=0 (falling edge vs. the registered `iVS`), active positions are loaded from pending positions. Only active positions are used for compositing.
- Hit test for sprite i: x_i ≤ `x` < x_i+SPR_W and y_i ≤ `y` < y_i+SPR_H. Comparisons use 11b/10b widths so there is no overflow.
- Priority: the lowest covering sprite index wins and outputs its `SPR_COLOR` slice. If no sprite covers the pixel, `iBG_BGR` passes through.
- `oBGR` is forced to 0 when the delayed blank qualifier is 0.
- Reset values:
  - `x`, `y`, tick counter: 0.
  - Sprite i pending and active positions: x = i·2·SPR_W (clamped), y = 0.
  - `oBGR` = 0, `oBLANK_n` = 0, `oHIT` = 0.

## Timing

- Latency: `iBG_BGR`/`iBLANK_n` to `oBGR`/`oBLANK_n` is exactly 2 cycles.
  - Stage 1 registers the per-sprite hit vector plus the background.
  - Stage 2 registers the mux output.
- `tick` and commit in the same cycle: commit loads pending positions as they stood before that tick. The tick's move is visible one frame later.
- A position change never takes effect mid-frame.
- Reset asserted mid-frame: all state returns to its reset value asynchronously. The first commit occurs at the next `iVS` falling edge.
- Key held across many ticks: one STEP per tick.

## Configuration

- `VGA_OVL_COLLIDE_EN` defined:
  - A sticky bit sets on any active pixel where sprite 0 and any other sprite both cover the pixel.
  - At commit, the sticky bit is copied to `oHIT` and then cleared.
  - `oHIT` therefore holds for one whole frame.
- `VGA_OVL_COLLIDE_EN` undefined: no collision logic; `oHIT` is tied 0.

## Test plan

Benches use MOVE_DIV=4, H_ACTIVE=16, V_ACTIVE=8, SPR_W=SPR_H=4, NUM_SPRITES=2.

- Reset, then one frame of background 24'hAAAAAA:
  - Sprite 0 colour appears at x 0..3, y 0..3.
  - Sprite 1 colour appears at x 8..11, y 0..3.
  - Background elsewhere.
  - Output delayed exactly 2 cycles.
- `iSEL`=0, `iKEY`=8'h74 for 3 ticks mid-frame:
  - Current frame unchanged.
  - After the next `iVS` falling edge, sprite 0 spans x 3..6.
- `iKEY`=8'h6B with sprite 0 at x=0, and 8'h74 with sprite 0 at x=12: x stays 0 and 12 respectively (saturation).
- Move sprite 0 to x=8 (overlaps sprite 1):
  - Overlap pixels show sprite 0 colour.
  - With `VGA_OVL_COLLIDE_EN`, `oHIT`=1 for the following frame, then 0 once separated.
- Assert `iRST_n`=0 mid-line:
  - `oBGR`=0, `oBLANK_n`=0, `oHIT`=0 immediately.
  - Sprite positions return to 0 and 8.
- `iSEL`=3, `iKEY`=8'h72 over 5 ticks: no sprite moves.
